// File: rtl/uart_rx_frame.sv
// uart_rx_frame: bit-level UART receiver, 8N1, LSB first.
// The raw rx pin is brought into the i_clk domain by a 2-FF synchroniser. A frame
// starts on a falling edge of the synchronised line. Each bit is sampled at mid-bit,
// and the completed byte is held until the consumer pulses flush.
//
// Ports
//   i_clk       in   1  system clock
//   i_rst       in   1  asynchronous, active-high reset
//   rx          in   1  raw serial line, idle high, asynchronous to i_clk
//   flush       in   1  consumer acknowledge; clears the pending frame
//   data        out  8  last completed byte
//   converted   out  1  frame pending, masked combinationally by flush
//   data_valid  out  1  pending frame had a good stop bit
//   busy        out  1  a frame is being received
//   overrun     out  1  sticky: a valid pending frame was overwritten before flush
module uart_rx_frame #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       rx,
    input  logic       flush,
    output logic [7:0] data,
    output logic       converted,
    output logic       data_valid,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            conv_q;
    logic            falling;
    logic            tick;
    logic            complete;

    // Synchroniser and edge detector reset to the idle (high) line level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Edge, not level: a held-low line (break) starts only one frame.
    assign falling  = rx_prev_q & ~rx_s_q;
    assign complete = (state_q == StStop) && tick;

    // End of the current sampling interval for the active state.
    always_comb begin
        tick = 1'b0;
        unique case (state_q)
            StStart:        tick = (cnt_q == HalfLast);
            StData, StStop: tick = (cnt_q == BitLast);
            default:        tick = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (falling) state_d = StStart;
            // A line back high at start-bit middle is a glitch: drop it silently.
            StStart: if (tick) state_d = rx_s_q ? StIdle : StData;
            StData:  if (tick && (bit_q == 3'd7)) state_d = StStop;
            StStop:  if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy      = (state_q != StIdle);
        converted = conv_q & ~flush;
    end

    // Bit timing, byte assembly and the pending-frame flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            conv_q     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cnt_q <= ((state_q == StIdle) || tick) ? '0 : cnt_q + 1'b1;

            if (state_q == StStart) begin
                bit_q <= '0;
            end else if ((state_q == StData) && tick) begin
                shift_q[bit_q] <= rx_s_q;
                bit_q          <= bit_q + 3'd1;
            end

            // Completion beats a simultaneous flush, but the flush still clears overrun.
            if (complete) begin
                data       <= shift_q;
                data_valid <= rx_s_q;
                conv_q     <= 1'b1;
                overrun    <= ~flush & (overrun | (conv_q & data_valid));
            end else if (flush) begin
                data_valid <= 1'b0;
                conv_q     <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

    localparam int unsigned Cpb  = 16;
    localparam int unsigned Half = 8;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       rx;
    logic       flush;
    logic       flush_man;
    logic       flush_auto;
    logic       cons_en;
    logic [7:0] data;
    logic       converted;
    logic       data_valid;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] log_q[$];

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[6];

    always #5 i_clk = ~i_clk;

    assign flush = flush_man | flush_auto;

    uart_rx_frame #(
        .CLK_FREQ    (1600),
        .BAUD        (100),
        .CLKS_PER_BIT(Cpb),
        .HALF_BIT    (Half)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .rx        (rx),
        .flush     (flush),
        .data      (data),
        .converted (converted),
        .data_valid(data_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Consumer model: acknowledge one clock after seeing a valid pending frame.
    always @(posedge i_clk) begin
        #1;
        flush_auto = cons_en && converted && data_valid;
        if (flush_auto) log_q.push_back(data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(Cpb);
    endtask

    // Line is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(b[k]);
        drive_bit(stop);
    endtask

    task automatic pulse_flush(input string name);
        flush_man = 1'b1;
        @(negedge i_clk);
        check({name, "_conv_masked"}, 32'(converted), 32'd0);
        @(posedge i_clk);
        #1;
        flush_man = 1'b0;
        @(negedge i_clk);
        check({name, "_conv_cleared"}, 32'(converted), 32'd0);
        check({name, "_valid_cleared"}, 32'(data_valid), 32'd0);
        idle(1);
    endtask

    initial begin
        int lat;
        int busy_low;
        int busy_cnt;

        vecs[0] = '{tx: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_valid: 1'b1};
        vecs[1] = '{tx: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_valid: 1'b1};
        vecs[2] = '{tx: 8'h81, stop: 1'b1, exp_data: 8'h81, exp_valid: 1'b1};
        vecs[3] = '{tx: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_valid: 1'b1};
        vecs[4] = '{tx: 8'hC3, stop: 1'b0, exp_data: 8'hC3, exp_valid: 1'b0};
        vecs[5] = '{tx: 8'h6E, stop: 1'b1, exp_data: 8'h6E, exp_valid: 1'b1};

        i_rst      = 1'b1;
        rx         = 1'b1;
        flush_man  = 1'b0;
        flush_auto = 1'b0;
        cons_en    = 1'b0;
        idle(3);
        @(negedge i_clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_converted", 32'(converted), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        idle(1);
        i_rst = 1'b0;
        idle(5);

        // 0xA5 with latency and busy coverage.
        lat      = -1;
        busy_low = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 159; i++) begin
                    @(negedge i_clk);
                    if (converted && lat < 0) lat = i;
                    if (i >= 4 && i <= 153 && !busy) busy_low++;
                end
            end
        join
        check("a5_latency_ok", 32'(lat >= 152 && lat <= 156), 32'd1);
        check("a5_busy_low_cycles", 32'(busy_low), 32'd0);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_valid", 32'(data_valid), 32'd1);
        check("a5_converted", 32'(converted), 32'd1);
        pulse_flush("a5");
        idle(10);

        // Table of single frames.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].tx, vecs[v].stop);
            @(negedge i_clk);
            check($sformatf("vec%0d_converted", v), 32'(converted), 32'd1);
            check($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_valid", v), 32'(data_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
            idle(1);
            pulse_flush($sformatf("vec%0d", v));
            rx = 1'b1;
            idle(20);
        end

        // Short glitch: START aborts, nothing reported.
        busy_cnt = 0;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_pulse_ok", 32'(busy_cnt >= 1 && busy_cnt <= 8), 32'd1);
        check("glitch_converted", 32'(converted), 32'd0);
        idle(5);

        // Framing error followed by a held-low break.
        send_frame(8'h3C, 1'b0);
        @(negedge i_clk);
        check("brk_converted", 32'(converted), 32'd1);
        check("brk_data", 32'(data), 32'h3C);
        check("brk_valid", 32'(data_valid), 32'd0);
        idle(1);
        pulse_flush("brk");
        busy_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            if (busy || converted) busy_cnt++;
        end
        check("brk_no_second_frame", 32'(busy_cnt), 32'd0);
        idle(1);
        rx = 1'b1;
        idle(20);

        // Overrun: two valid frames without a flush.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        @(negedge i_clk);
        check("ovr_data", 32'(data), 32'h22);
        check("ovr_valid", 32'(data_valid), 32'd1);
        check("ovr_converted", 32'(converted), 32'd1);
        check("ovr_overrun", 32'(overrun), 32'd1);
        idle(1);
        pulse_flush("ovr");
        @(negedge i_clk);
        check("ovr_overrun_cleared", 32'(overrun), 32'd0);
        idle(10);

        // Consumer model over 16 back-to-back frames.
        log_q.delete();
        cons_en = 1'b1;
        for (int b = 0; b < 16; b++) send_frame(8'(b), 1'b1);
        idle(20);
        cons_en = 1'b0;
        @(negedge i_clk);
        check("cons_count", 32'(log_q.size()), 32'd16);
        check("cons_overrun", 32'(overrun), 32'd0);
        for (int b = 0; b < 16; b++) begin
            if (b < log_q.size()) check($sformatf("cons_byte%0d", b), 32'(log_q[b]), 32'(b));
        end
        idle(10);

        // Reset in the middle of bit 4, with an older frame still pending.
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(1'b1);
        rx = 1'b1;
        idle(Half);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_converted", 32'(converted), 32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        idle(3);
        i_rst = 1'b0;
        idle(40);
        check("post_rst_idle", 32'(busy | converted), 32'd0);
        send_frame(8'h7E, 1'b1);
        @(negedge i_clk);
        check("post_rst_data", 32'(data), 32'h7E);
        check("post_rst_valid", 32'(data_valid), 32'd1);
        check("post_rst_converted", 32'(converted), 32'd1);
        idle(1);
        pulse_flush("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
